// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: opcode constants, FSM state and instruction class encodings
package fetch_sequencer_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        C_SEQ, C_BEQ, C_BNE, C_JMP, C_JR, C_HALT
    } iclass_t;
endpackage

// File: rtl/fetch_decode.sv
// fetch_decode: combinational instruction classifier on opcode and funct fields
module fetch_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] i_ir,
    output iclass_t     o_class
);
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_op     = i_ir[31:26];
    assign w_funct  = i_ir[5:0];
    assign w_unused = ^i_ir[25:6];

    always_comb begin
        o_class = (w_op == OP_BEQ)                           ? C_BEQ  :
                  (w_op == OP_BNE)                           ? C_BNE  :
                  (w_op == OP_J || w_op == OP_JAL)           ? C_JMP  :
                  (w_op == OP_RTYPE && w_funct == FUNCT_JR)  ? C_JR   :
                  (w_op == OP_HALT)                          ? C_HALT : C_SEQ;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/decode/exec/update controller for the PC datapath
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             imem_ready,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      ir,
    output logic             pc_enable,
    output logic             branch,
    output logic             jmp,
    output logic             jmp_r,
    output logic             halted,
    output logic             fetch_error,
    output logic [CNT_W-1:0] retired
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    iclass_t          r_class;
    iclass_t          w_class;
    logic             r_take;
    logic [31:0]      r_ir;
    logic [TW-1:0]    r_tcount;
    logic [CNT_W-1:0] r_retired;

    fetch_decode u_decode (
        .i_ir    (r_ir),
        .o_class (w_class)
    );

    assign ir          = r_ir;
    assign retired     = r_retired;
    assign halted      = (r_state == S_HALT);
    assign fetch_error = (r_state == S_ERROR);

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        pc_enable = 1'b0;
        branch    = 1'b0;
        jmp       = 1'b0;
        jmp_r     = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                w_next   = imem_ready ? S_DECODE : (r_tcount == T_LAST) ? S_ERROR : S_FETCH;
            end
            S_DECODE: w_next = (w_class == C_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = S_UPDATE;
            S_UPDATE: begin
                branch    = r_take;
                jmp       = (r_class == C_JMP);
                jmp_r     = (r_class == C_JR);
                // a reset arriving mid-UPDATE must not leak a PC write
                pc_enable = ~stall & reset_n;
                w_next    = stall ? S_UPDATE : S_FETCH;
            end
            default:  w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_class   <= C_SEQ;
            r_take    <= 1'b0;
            r_ir      <= '0;
            r_tcount  <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                if (imem_ready) begin
                    r_ir     <= instr;
                    r_tcount <= '0;
                end else begin
                    r_tcount <= r_tcount + 1'b1;
                end
            end
            if (r_state == S_DECODE)
                r_class <= w_class;
            if (r_state == S_EXEC)
                r_take <= (r_class == C_BEQ && alu_zero) || (r_class == C_BNE && !alu_zero);
            if (r_state == S_UPDATE && !stall)
                r_retired <= r_retired + 1'b1;
        end
    end
endmodule
